// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the
// 128-word data memory. Port 0 is the CPU load/store port, port 1 is the
// DMA/debug port. Each granted access walks IDLE -> ACCESS -> (RDWAIT) -> DONE.
// Memory strobes are high only during ACCESS. ack is a one-cycle pulse in DONE.
//
// Ports:
//   clock, reset          clock; async active-low reset
//   reqN/weN/addrN/wdataN request side of port N (held until ackN)
//   ackN/rdataN/errN      completion pulse, read data, range error (qualified by ack)
//   busy                  FSM not in IDLE
//   mem_adress/mem_write_data/mem_write/mem_read  registered memory controls
//   mem_data              memory's registered read output
//
// Optional feature: define DMEM_ARB_RANGE_CHECK_EN to reject addresses with
// any bit set above bit 6 (ack + err after one cycle, no memory strobe).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [1:0]        ack_q, ack_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic [1:0]        err_q, err_d;
`endif

  // Grant candidate: on a tie the port that did not win last time;
  // otherwise whichever single port is requesting.
  logic              g_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign g_sel     = (req0 & req1) ? ~last_q : req1;
  assign sel_we    = g_sel ? we1    : we0;
  assign sel_addr  = g_sel ? addr1  : addr0;
  assign sel_wdata = g_sel ? wdata1 : wdata0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    ack_d       = 2'b00;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    err_d       = 2'b00;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          last_d      = g_sel;
          gnt_d       = g_sel;
          we_d        = sel_we;
          // mem_adress/mem_write_data double as the latched request fields
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
`ifdef DMEM_ARB_RANGE_CHECK_EN
          if (|sel_addr[ADDR_W-1:7]) begin
            state_d      = S_DONE;
            ack_d[g_sel] = 1'b1;
            err_d[g_sel] = 1'b1;
          end else begin
            state_d  = S_ACCESS;
            mem_wr_d = sel_we;
            mem_rd_d = ~sel_we;
          end
`else
          state_d  = S_ACCESS;
          mem_wr_d = sel_we;
          mem_rd_d = ~sel_we;
`endif
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d      = S_DONE;
          ack_d[gnt_q] = 1'b1;
        end else begin
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (gnt_q) rdata1_d = mem_data;
        else       rdata0_d = mem_data;
        state_d      = S_DONE;
        ack_d[gnt_q] = 1'b1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      ack_q       <= 2'b00;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
      err_q       <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign ack0           = ack_q[0];
  assign ack1           = ack_q[1];
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign busy           = (state_q != S_IDLE);
  assign mem_adress     = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_write      = mem_wr_q;
  assign mem_read       = mem_rd_q;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign err0 = err_q[0];
  assign err1 = err_q[1];
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter (default build, range
// check disabled). A 128-word memory with registered read output sits
// behind the arbiter; expected values are hand-computed constants.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, err0, err1, busy, mem_write, mem_read;
  logic [31:0] rdata0, rdata1, mem_adress, mem_write_data;
  logic [31:0] mem_data;

  logic [31:0] mem [0:127];

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [31:0] strobe_addr = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .busy(busy),
    .mem_adress(mem_adress), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data(mem_data)
  );

  always #5 clock = ~clock;

  // memory with registered read port
  always @(posedge clock) begin
    if (mem_write) mem[mem_adress[6:0]] <= mem_write_data;
    if (mem_read)  mem_data <= mem[mem_adress[6:0]];
  end

  // strobe monitor
  always @(negedge clock) begin
    if (mem_write) begin wr_cnt++; strobe_addr = mem_adress; end
    if (mem_read)  begin rd_cnt++; strobe_addr = mem_adress; end
    if (mem_write && mem_read) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One access on port p, starting from a known-IDLE cycle. lat counts
  // rising edges from the sampling edge up to the one that raises ack.
  task automatic access(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
    @(posedge clock); #1;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if ((p == 0) ? ack0 : ack1) begin lat = i; break; end
    end
    rd = (p == 0) ? rdata0 : rdata1;
    req0 = 0; req1 = 0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, w0, r0;
    int ord [4];
    int cyc [4];
    int na;

    // reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack0", {31'b0, ack0}, 0);
    chk("rst_ack1", {31'b0, ack1}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mwr",  {31'b0, mem_write}, 0);
    chk("rst_mrd",  {31'b0, mem_read}, 0);
    chk("rst_err",  {30'b0, err1, err0}, 0);
    chk("rst_rd0",  rdata0, 0);
    chk("rst_rd1",  rdata1, 0);
    chk("rst_addr", mem_adress, 0);
    chk("rst_wdat", mem_write_data, 0);
    @(negedge clock); reset = 1;

    // write then read, port 0
    w0 = wr_cnt;
    access(0, 1, 13, 32'hDEADBEEF, rd, lat);
    chk("wr_lat",   lat, 2);
    chk("wr_pulse", wr_cnt - w0, 1);
    chk("wr_addr",  strobe_addr, 13);
    chk("wr_mem",   mem[13], 32'hDEADBEEF);
    r0 = rd_cnt;
    access(0, 0, 13, 0, rd, lat);
    chk("rd_lat",   lat, 3);
    chk("rd_data",  rd, 32'hDEADBEEF);
    chk("rd_pulse", rd_cnt - r0, 1);

    // preload through port 1
    access(1, 1, 5, 32'h55, rd, lat);
    access(1, 1, 9, 32'h99, rd, lat);
    access(0, 1, 7, 32'h77, rd, lat);
    chk("pre_lat", lat, 2);

    // round-robin tie right after reset
    @(negedge clock); reset = 0;
    @(negedge clock); reset = 1;
    @(posedge clock); #1;
    req0 = 1; we0 = 0; addr0 = 7;
    req1 = 1; we1 = 0; addr1 = 5;
    na = 0;
    for (int c = 1; c <= 40 && na < 4; c++) begin
      @(posedge clock); #1;
      if (ack0 && ack1) chk("rr_dual_ack", 1, 0);
      if (ack0 && na < 4) begin ord[na] = 0; cyc[na] = c; na++; end
      if (ack1 && na < 4) begin ord[na] = 1; cyc[na] = c; na++; end
    end
    req0 = 0; req1 = 0;
    chk("rr_nack", na, 4);
    if (na == 4) begin
      chk("rr_first_lat", cyc[0], 3);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_order%0d", i), ord[i], i % 2);
        if (i > 0) chk($sformatf("rr_gap%0d", i), cyc[i] - cyc[i-1], 4);
      end
    end
    chk("rr_rd0", rdata0, 32'h77);
    chk("rr_rd1", rdata1, 32'h55);
    chk("rr_both", both_cnt, 0);

    // inputs changed after grant are ignored
    @(posedge clock); #1;
    req1 = 1; we1 = 0; addr1 = 5;
    @(posedge clock); #1;              // now in ACCESS
    addr1 = 9;
    chk("chg_addr", mem_adress, 5);
    lat = 99;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clock); #1;
      if (ack1) begin lat = i; break; end
    end
    req1 = 0;
    chk("chg_lat", lat, 3);
    chk("chg_rd1", rdata1, 32'h55);
    chk("chg_rd0", rdata0, 32'h77);

    // reset during RDWAIT
    @(posedge clock); #1;
    req0 = 1; we0 = 0; addr0 = 9;
    @(posedge clock);                  // sampled -> ACCESS
    @(posedge clock); #1;              // RDWAIT
    chk("mid_busy_pre", {31'b0, busy}, 1);
    reset = 0; #1;
    chk("mid_busy", {31'b0, busy}, 0);
    chk("mid_ack",  {31'b0, ack0}, 0);
    chk("mid_rd0",  rdata0, 0);
    req0 = 0;
    @(posedge clock); #1;
    chk("mid_noack", {31'b0, ack0}, 0);
    @(negedge clock); reset = 1;
    access(0, 0, 9, 0, rd, lat);
    chk("post_lat", lat, 3);
    chk("post_rd",  rd, 32'h99);

    // upper address bits alias onto the 7-bit memory index
    w0 = wr_cnt;
    access(0, 1, 32'h80, 32'hA5A5, rd, lat);
    chk("alias_lat",  lat, 2);
    chk("alias_pulse", wr_cnt - w0, 1);
    chk("alias_addr", strobe_addr, 32'h80);
    chk("alias_err",  {31'b0, err0}, 0);
    chk("alias_mem",  mem[0], 32'hA5A5);
    access(1, 0, 0, 0, rd, lat);
    chk("alias_rd",   rd, 32'hA5A5);
    chk("end_both",   both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 128-word data memory. It shares the memory between the CPU load/store port (port 0) and a secondary DMA/debug port (port 1). Each access runs through a small FSM that drives the memory's `mem_write`/`mem_read` strobes for exactly one cycle and returns a one-cycle `ack`. Concurrent requests are resolved by round-robin.

## Interface
Parameters:
- `ADDR_W`, 32: requester and memory address width.
- `DATA_W`, 32: data width.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held high until the matching `ack`.
- `we0` / `we1`  in  1  1 = write, 0 = read; held stable with `req`.
- `addr0` / `addr1`  in  ADDR_W  word address; memory uses bits [6:0].
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  read result; valid while `ack` is high, holds until the next read on that port.
- `err0` / `err1`  out  1  range error, qualified by `ack`. Exists only with the range-check macro defined; otherwise tied to 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `mem_adress`  out  ADDR_W  to memory `adress`.
- `mem_write_data`  out  DATA_W  to memory `write_data`.
- `mem_write` / `mem_read`  out  1  memory strobes; never both high.
- `mem_data`  in  DATA_W  memory's registered read output.

## Operation
FSM states:
- **IDLE**
  - No request: stay in IDLE.
  - Any `req` high: grant one port, latch its `we`, `addr` and `wdata`, go to ACCESS.
- **ACCESS**
  - Drive `mem_adress` and `mem_write_data` from the latched values.
  - Assert `mem_write` if the latched `we` = 1, else `mem_read`.
  - Next state: DONE for a write, RDWAIT for a read.
- **RDWAIT**
  - `mem_data` is valid this cycle.
  - Capture it into the granted port's `rdata`, then go to DONE.
- **DONE**
  - Granted port's `ack` = 1 for exactly this cycle, then go to IDLE.

Arbitration:
- Round-robin pointer `last` records the most recently granted port.
- Both ports requesting in IDLE: the port not equal to `last` wins.
- Single requester: that port wins regardless of `last`.
- `last` updates only on a grant.

Handshake rules:
- A requester drops `req`, or presents its next request, in the cycle after `ack`.
- A `req` still high in IDLE after `ack` is treated as a new request.
- `req`, `we`, `addr` and `wdata` are sampled only in IDLE. Changes after the grant are ignored.
- The ungranted port waits with `ack` = 0. Its `rdata` is unchanged.

Memory outputs:
- Registered.
- `mem_write` and `mem_read` are 0 in every state except ACCESS.
- Address and write data are don't-care outside ACCESS and are held at their last value.

## Timing
- Request first seen high in IDLE at edge E.
  - Write: ACCESS during cycle E+1, `ack` during cycle E+2 (2-cycle latency).
  - Read: ACCESS during E+1, RDWAIT during E+2, `ack` and `rdata` during E+3 (3-cycle latency).
- Throughput: one access per 3 cycles (write) or 4 cycles (read), because IDLE is always visited between accesses.
- Reset asserted (low), asynchronously:
  - State → IDLE.
  - `last` = 1, so port 0 wins the first tie.
  - All `ack`, `err`, `mem_write`, `mem_read`, `busy` = 0.
  - `rdata0`, `rdata1`, `mem_adress`, `mem_write_data` = 0.
- Reset mid-access: the in-flight access is abandoned with no `ack`. A memory write already strobed is not undone.
- Reset release: the first IDLE sample occurs on the first rising edge with `reset` high.

## Configuration
- `DMEM_ARB_RANGE_CHECK_EN` defined:
  - In IDLE, a granted request with `addr[ADDR_W-1:7]` ≠ 0 skips ACCESS and RDWAIT and goes directly to DONE.
  - No memory strobe is issued.
  - `ack` = 1 with `err` = 1 (1-cycle latency). `rdata` is unchanged.
  - The round-robin pointer still updates.
- Macro not defined:
  - No range check; the upper address bits pass to memory, which aliases via [6:0].
  - `err0` and `err1` are constant 0.

## Test plan
- **Reset values:** hold `reset` low, toggle `clock` → all outputs 0, `busy` = 0. Release → IDLE.
- **Single write then read, port 0:**
  - Write `addr0` = 13, `wdata0` = 32'hDEADBEEF → `mem_write` high one cycle with `mem_adress` = 13; `ack0` 2 cycles after the sampling edge.
  - Read addr 13 → `mem_read` one cycle; `ack0` after 3 cycles with `rdata0` = 32'hDEADBEEF.
- **Round-robin tie:** both ports hold read requests continuously after reset → grant order 0, 1, 0, 1. Each `ack` separated by 4 cycles. `mem_write` and `mem_read` never both high.
- **Input change after grant:** change `addr1` from 5 to 9 during ACCESS → memory sees 5; `rdata1` = mem[5].
- **Reset mid-read:** assert reset during RDWAIT → no `ack`, state IDLE, `rdata` = 0. A subsequent read completes normally.
- **Range check (macro defined):** `addr0` = 32'h80 → `ack0` = 1 and `err0` = 1 one cycle after sampling, no memory strobe. Without the macro → normal write to mem[0].
